iter_sched: RTL and testbench

ITER_SCHED -- requirements
Module: iter_sched

---
 rtl/pagerank_pkg.sv | 20 ++
 rtl/ant_barrier.sv | 54 +++++
 rtl/iter_sched.sv | 136 +++++++++++++
 tb/tb_iter_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pagerank_pkg.sv
// Shared FSM state type and default sizing constants for the PageRank
// iteration scheduler slice.
package pagerank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_SORT,
      ST_DONE
   } sched_state_t;

   localparam int unsigned DEF_NUM_ANTS = 4;
   localparam int unsigned DEF_WIDTH    = 16;
   localparam int unsigned DEF_MAX_ITER = 400;
   localparam int unsigned DEF_ITER_W   = 9;
   localparam int unsigned DEF_EPS      = 4;
   localparam int unsigned DEF_TIMEOUT  = 1023;
   localparam int unsigned DEF_TO_W     = 10;

endpackage

// File: rtl/ant_barrier.sv
// Per-ant barrier bookkeeping: sticky arrival bits, latest residual per ant,
// registered all-arrived flag and all-below-EPS flag over the stored residuals.
module ant_barrier
   import pagerank_pkg::*;
#(
   parameter int unsigned NUM_ANTS = DEF_NUM_ANTS,
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned EPS      = DEF_EPS
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      capture_en,
   input  logic                      clear,
   input  logic [NUM_ANTS-1:0]       ant_ready,
   input  logic [NUM_ANTS*WIDTH-1:0] ant_delta,
   output logic                      all_arrived,
   output logic                      all_below
);

   logic [NUM_ANTS-1:0] hit;
   logic [NUM_ANTS-1:0] arrived_q;
   logic [NUM_ANTS-1:0] arrived_d;
   logic [NUM_ANTS-1:0] below;

   assign hit       = capture_en ? ant_ready : '0;
   assign arrived_d = arrived_q | hit;

   // Flag folds in this cycle's arrivals so the scheduler acts one cycle later.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         arrived_q   <= '0;
         all_arrived <= 1'b0;
      end else begin
         arrived_q   <= arrived_d;
         all_arrived <= &arrived_d;
      end
   end

   for (genvar g = 0; g < NUM_ANTS; g++) begin : g_ant
      logic [WIDTH-1:0] delta_q;

      always_ff @(posedge clk) begin
         if (reset)
            delta_q <= '1;
         else if (hit[g])
            delta_q <= ant_delta[g*WIDTH +: WIDTH];
      end

      assign below[g] = (delta_q < WIDTH'(EPS));
   end

   assign all_below = &below;

endmodule

// File: rtl/iter_sched.sv
// Iteration scheduler: releases all ants per iteration, waits on the barrier,
// stops on convergence, iteration cap or watchdog, then hands off to the sorter.
module iter_sched
   import pagerank_pkg::*;
#(
   parameter int unsigned NUM_ANTS = DEF_NUM_ANTS,
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned MAX_ITER = DEF_MAX_ITER,
   parameter int unsigned ITER_W   = DEF_ITER_W,
   parameter int unsigned EPS      = DEF_EPS,
   parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
   parameter int unsigned TO_W     = DEF_TO_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [NUM_ANTS-1:0]       ant_ready,
   input  logic [NUM_ANTS*WIDTH-1:0] ant_delta,
   input  logic                      sort_done,
   output logic                      ant_go,
   output logic                      sort_start,
   output logic [ITER_W-1:0]         iter_count,
   output logic                      busy,
   output logic                      done,
   output logic                      converged,
   output logic                      timeout_err
);

   sched_state_t      state_q, state_d;
   logic [ITER_W-1:0] iter_q, iter_d, iter_inc;
   logic [TO_W-1:0]   wd_q, wd_d;
   logic              go_q, go_d;
   logic              sstart_q, sstart_d;
   logic              conv_q, conv_d;
   logic              terr_q, terr_d;
   logic              clear;
   logic              all_arrived, all_below;

   ant_barrier #(
      .NUM_ANTS (NUM_ANTS),
      .WIDTH    (WIDTH),
      .EPS      (EPS)
   ) u_barrier (
      .clk         (clk),
      .reset       (reset),
      .capture_en  ((state_q == ST_RUN) && !go_q),
      .clear       (clear),
      .ant_ready   (ant_ready),
      .ant_delta   (ant_delta),
      .all_arrived (all_arrived),
      .all_below   (all_below)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         iter_q   <= '0;
         wd_q     <= '0;
         go_q     <= 1'b0;
         sstart_q <= 1'b0;
         conv_q   <= 1'b0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         iter_q   <= iter_d;
         wd_q     <= wd_d;
         go_q     <= go_d;
         sstart_q <= sstart_d;
         conv_q   <= conv_d;
         terr_q   <= terr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      iter_d   = iter_q;
      wd_d     = wd_q;
      go_d     = 1'b0;
      sstart_d = 1'b0;
      conv_d   = conv_q;
      terr_d   = terr_q;
      clear    = 1'b0;
      iter_inc = (iter_q == ITER_W'(MAX_ITER)) ? iter_q : iter_q + ITER_W'(1);

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               iter_d  = '0;
               wd_d    = '0;
               conv_d  = 1'b0;
               terr_d  = 1'b0;
               go_d    = 1'b1;
               clear   = 1'b1;
            end
         end
         ST_RUN: begin
            // A completed barrier outranks a watchdog expiry in the same cycle.
            if (all_arrived) begin
               iter_d = iter_inc;
               if (all_below) begin
                  conv_d   = 1'b1;
                  state_d  = ST_SORT;
                  sstart_d = 1'b1;
               end else if (iter_inc == ITER_W'(MAX_ITER)) begin
                  state_d  = ST_SORT;
                  sstart_d = 1'b1;
               end else begin
                  go_d  = 1'b1;
                  clear = 1'b1;
                  wd_d  = '0;
               end
            end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
               terr_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               wd_d = wd_q + TO_W'(1);
            end
         end
         ST_SORT: begin
            if (sort_done)
               state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign ant_go      = go_q;
   assign sort_start  = sstart_q;
   assign iter_count  = iter_q;
   assign busy        = (state_q == ST_RUN) || (state_q == ST_SORT);
   assign done        = (state_q == ST_DONE);
   assign converged   = conv_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_iter_sched.sv
// Self-checking bench for iter_sched: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_iter_sched;

   localparam int NA   = 4;
   localparam int W    = 16;
   localparam int IW   = 9;
   localparam int TW   = 10;
   localparam int MAXI = 400;
   localparam int EPSV = 4;
   localparam int TMO  = 1023;

   logic              clk = 1'b0;
   logic              reset, start, sort_done;
   logic [NA-1:0]     ant_ready;
   logic [NA-1:0][W-1:0] dvec;
   logic [NA*W-1:0]   ant_delta;
   logic              ant_go, sort_start, busy, done, converged, timeout_err;
   logic [IW-1:0]     iter_count;

   assign ant_delta = dvec;

   iter_sched #(
      .NUM_ANTS (NA),
      .WIDTH    (W),
      .MAX_ITER (MAXI),
      .ITER_W   (IW),
      .EPS      (EPSV),
      .TIMEOUT  (TMO),
      .TO_W     (TW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .ant_ready   (ant_ready),
      .ant_delta   (ant_delta),
      .sort_done   (sort_done),
      .ant_go      (ant_go),
      .sort_start  (sort_start),
      .iter_count  (iter_count),
      .busy        (busy),
      .done        (done),
      .converged   (converged),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int go_cnt   = 0;
   int ss_cnt   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [IW+5:0] outs();
      return {ant_go, sort_start, busy, done, converged, timeout_err, iter_count};
   endfunction

   // Behavioural reference: run phase, per-ant arrival flags and latest residuals.
   typedef enum {M_IDLE, M_RUN, M_SORT, M_DONE} mphase_t;
   mphase_t     ph = M_IDLE;
   bit          m_valid = 0, e_go = 0, e_ss = 0, m_conv = 0, m_terr = 0;
   int          m_iter = 0, since_go = 0;
   bit          arr [NA];
   int unsigned dm  [NA];

   always @(negedge clk) begin
      bit all_arr, all_low, take, ngo, nss;
      if (ant_go === 1'b1) go_cnt++;
      if (sort_start === 1'b1) ss_cnt++;
      if (m_valid)
         check("cycle", outs(),
               {e_go, e_ss, (ph == M_RUN) || (ph == M_SORT), ph == M_DONE, m_conv, m_terr, IW'(m_iter)});
      if (reset === 1'b1) begin
         ph = M_IDLE; m_iter = 0; m_conv = 0; m_terr = 0;
         e_go = 0; e_ss = 0; since_go = 0;
         for (int i = 0; i < NA; i++) begin arr[i] = 0; dm[i] = 32'hFFFF; end
         m_valid = 1;
      end else if (m_valid) begin
         take = (ph == M_RUN) && !e_go;
         ngo = 0; nss = 0; all_arr = 1; all_low = 1;
         for (int i = 0; i < NA; i++) begin
            if (!arr[i]) all_arr = 0;
            if (dm[i] >= EPSV) all_low = 0;
         end
         case (ph)
            M_IDLE, M_DONE:
               if (start) begin
                  ph = M_RUN; m_iter = 0; m_conv = 0; m_terr = 0; since_go = 0; ngo = 1;
               end
            M_RUN:
               if (all_arr) begin
                  if (m_iter < MAXI) m_iter++;
                  if (all_low) begin m_conv = 1; ph = M_SORT; nss = 1; end
                  else if (m_iter == MAXI) begin ph = M_SORT; nss = 1; end
                  else begin ngo = 1; since_go = 0; end
               end else if (since_go + 1 == TMO) begin
                  m_terr = 1; ph = M_DONE;
               end else begin
                  since_go++;
               end
            M_SORT: if (sort_done) ph = M_DONE;
            default: ;
         endcase
         for (int i = 0; i < NA; i++)
            if (take && ant_ready[i]) begin dm[i] = dvec[i]; arr[i] = 1; end
         if (ngo) for (int i = 0; i < NA; i++) arr[i] = 0;
         e_go = ngo;
         e_ss = nss;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         start = 0; ant_ready = '0; sort_done = 0;
      end
   endtask

   // sel: 0 ant_go, 1 sort_start, otherwise done
   task automatic wait_for(input int sel, input int bound, output bit ok);
      ok = 0;
      for (int k = 0; k < bound && !ok; k++) begin
         step(1);
         case (sel)
            0:       ok = (ant_go === 1'b1);
            1:       ok = (sort_start === 1'b1);
            default: ok = (done === 1'b1);
         endcase
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      bit ok;
      int g, bad, first, n_go, it_at, ss_base;
      reset = 1; start = 0; sort_done = 0; ant_ready = '0; dvec = '0;
      step(3);
      check("reset_outputs", outs(), '0);
      reset = 0;
      step(2);

      // Full run to the iteration cap, ants answering 10 cycles after each ant_go.
      start = 1;
      wait_for(0, 4, ok);
      check("first_go", ok, 1);
      g = cyc; bad = 0; ss_base = ss_cnt;
      for (int it = 1; it <= MAXI; it++) begin
         step(10);
         ant_ready = '1;
         for (int i = 0; i < NA; i++) dvec[i] = 16'd100;
         wait_for((it < MAXI) ? 0 : 1, 20, ok);
         if (!ok || (cyc - g) != 12) bad++;
         g = cyc;
      end
      check("max_gap12", bad, 0);
      check("max_iter", iter_count, MAXI);
      check("max_not_conv", converged, 0);
      step(3);
      check("max_sort_wait", {busy, done}, 2'b10);
      check("max_one_sstart", ss_cnt - ss_base, 1);
      sort_done = 1;
      step(1);
      check("max_done", {done, busy, converged, timeout_err}, 4'b1000);
      check("max_iter_held", iter_count, MAXI);

      // Restart from DONE; converge on the fifth iteration; start ignored in RUN/SORT.
      start = 1;
      step(1);
      check("restart_from_done", {done, ant_go, busy}, 3'b011);
      check("restart_iter0", iter_count, 0);
      bad = 0;
      for (int it = 1; it <= 5; it++) begin
         step(2);
         start = 1;
         step(3);
         ant_ready = '1;
         for (int i = 0; i < NA; i++) dvec[i] = (it < 5) ? 16'd100 : 16'd2;
         if (it == 5) dvec[2] = 16'd3;
         wait_for((it < 5) ? 0 : 1, 10, ok);
         if (!ok) bad++;
      end
      check("conv_flow", bad, 0);
      check("conv_flag", converged, 1);
      check("conv_iter5", iter_count, 5);
      step(1);
      start = 1;
      step(1);
      check("start_in_sort", {busy, done, ant_go, sort_start}, 4'b1000);
      sort_done = 1;
      step(1);
      check("conv_done", {done, converged, timeout_err}, 3'b110);

      // Ant 3 never reports: watchdog ends the run.
      start = 1;
      wait_for(0, 4, ok);
      g = cyc; ss_base = ss_cnt;
      for (int i = 0; i < NA; i++) dvec[i] = 16'd100;
      step(5);
      ant_ready = 4'b0111;
      wait_for(2, 1100, ok);
      check("to_seen", ok, 1);
      check("to_latency", cyc - g, TMO);
      check("to_flags", {timeout_err, converged, busy}, 3'b100);
      check("to_iter0", iter_count, 0);
      step(1);
      check("to_no_sstart", ss_cnt - ss_base, 0);

      // Staggered arrivals with a duplicate pulse and a stray start.
      start = 1;
      wait_for(0, 4, ok);
      first = 0; n_go = 0; it_at = -1;
      for (int k = 1; k <= 25; k++) begin
         step(1);
         if (ant_go === 1'b1) begin
            n_go++;
            if (first == 0) begin first = k; it_at = int'(iter_count); end
         end
         case (k)
            3:       ant_ready[0] = 1'b1;
            5:       start = 1;
            7:       ant_ready[2:1] = 2'b11;
            9:       ant_ready[0] = 1'b1;
            20:      ant_ready[3] = 1'b1;
            default: ;
         endcase
      end
      check("stagger_go_at", first, 22);
      check("stagger_one_go", n_go, 1);
      check("stagger_iter1", it_at, 1);

      // Converge into SORT, then reset mid-SORT and start afresh.
      step(2);
      ant_ready = '1;
      for (int i = 0; i < NA; i++) dvec[i] = 16'd1;
      wait_for(1, 10, ok);
      check("pre_rst_sort", ok, 1);
      step(2);
      reset = 1;
      step(1);
      check("rst_mid_sort", outs(), '0);
      reset = 0;
      step(1);
      check("rst_release_quiet", outs(), '0);
      start = 1;
      step(1);
      check("post_rst_go", {ant_go, busy}, 2'b11);
      check("post_rst_iter0", iter_count, 0);

      // Randomized traffic, including protocol violations and occasional resets.
      for (int c = 0; c < 4000; c++) begin
         step(1);
         reset     = ($urandom_range(399, 0) == 0);
         start     = ($urandom_range(24, 0) == 0);
         sort_done = ($urandom_range(5, 0) == 0);
         for (int i = 0; i < NA; i++) begin
            ant_ready[i] = ($urandom_range(5, 0) == 0);
            dvec[i] = ($urandom_range(9, 0) < 7) ? 16'($urandom_range(5, 0)) : 16'($urandom);
         end
      end
      reset = 0;
      step(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
